radix4_booth: RTL and testbench

Sequential signed 8x8 multiplier for the switch/display front-end. The user enters two operands on an 8-bit switch bank, each latched by a rising edge on `go`. The block multiplies them with radix-4 Booth recoding, one recoded digit per clock, and presents the 16-bit two's-complement product on `display`. It sits between the board I/O (switches, push-button, 7-segment driver) and has no other system connections.

---
 rtl/radix4_booth_if.sv | 16 +
 rtl/radix4_booth.sv | 116 +++++++++++
 tb/tb_radix4_booth.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/radix4_booth_if.sv
// Operand/result bundle between the board I/O and the Booth multiplier.
// Capture handshake: the source presents an operand on sw and raises go.
// A capture takes place on the first clock edge that samples go high after it
// was sampled low (or right after reset). There is no ready signal. A rise
// while the multiplier is busy (states INIT/CALC) is dropped, not queued.
// The source must take go low for at least one sampled cycle before the next
// capture.
interface radix4_booth_if;
   logic [7:0]  sw;
   logic        go;
   logic [15:0] display;
   logic [2:0]  state;

   modport master (output sw, go, input display, state);
   modport slave  (input sw, go, output display, state);
endinterface

// File: rtl/radix4_booth.sv
// Sequential signed 8x8 multiplier using radix-4 Booth recoding.
// Operand A and operand B are captured on successive go rises. The block then
// adds one recoded digit per clock, for four digits. The 16-bit signed product
// is held on display until the next A capture.
module radix4_booth (
   input  logic           clk,
   input  logic           rst,
   radix4_booth_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GOT_A = 3'd1,
      INIT  = 3'd2,
      CALC  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic               go_q;
   logic               go_rise;
   logic signed [7:0]  a_q;
   logic signed [7:0]  b_q;
   logic [15:0]        acc_q;
   logic [1:0]         cnt_q;
   logic [15:0]        display_q;

   logic [8:0]         b_ext;
   logic [2:0]         shamt;
   logic [2:0]         triple;
   logic [15:0]        a_ext;
   logic [15:0]        pp;
   logic [15:0]        pp_shift;
   logic [15:0]        acc_sum;

   assign go_rise     = bus.go & ~go_q;
   assign bus.display = display_q;
   assign bus.state   = state_q;

   // Recode the current digit of B and form the shifted partial product.
   always_comb begin
      b_ext  = {b_q, 1'b0};          // the appended zero supplies B[-1]
      shamt  = {cnt_q, 1'b0};        // digit i covers bits 2i+1..2i-1
      triple = b_ext[shamt +: 3];
      a_ext  = {{8{a_q[7]}}, a_q};
      pp     = 16'd0;
      case (triple)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = 16'd0 - (a_ext << 1);
         3'b101, 3'b110: pp = 16'd0 - a_ext;
         default:        pp = 16'd0;
      endcase
      pp_shift = pp << shamt;
      acc_sum  = acc_q + pp_shift;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic. Unused codes fall back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go_rise) state_d = GOT_A;
         GOT_A:   if (go_rise) state_d = INIT;
         INIT:    state_d = CALC;
         CALC:    if (cnt_q == 2'd3) state_d = DONE;
         DONE:    if (go_rise) state_d = GOT_A;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, digit accumulation and display update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         go_q      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         display_q <= '0;
      end else begin
         go_q <= bus.go;   // tracks go in every state so busy-time rises are dropped
         case (state_q)
            IDLE, DONE: begin
               if (go_rise) begin
                  a_q       <= bus.sw;
                  display_q <= {bus.sw, 8'h00};
               end
            end
            GOT_A: begin
               if (go_rise) begin
                  b_q       <= bus.sw;
                  display_q <= {a_q, bus.sw};
               end
            end
            INIT: begin
               acc_q <= '0;
               cnt_q <= '0;
            end
            CALC: begin
               acc_q <= acc_sum;
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) display_q <= acc_sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_radix4_booth.sv
// Bench for radix4_booth: directed cases plus random operand pairs. Each
// expected product goes into a queue when B is captured. A monitor pops the
// queue when the DUT enters DONE and checks both the product and the latency.
module tb_radix4_booth;

   logic clk = 1'b0;
   logic rst = 1'b0;

   radix4_booth_if bus ();

   radix4_booth dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [15:0] exp_q[$];
   int          cap_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  cur_a;
   logic [2:0]  prev_state = 3'd0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed multiplication, truncated to 16 bits.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
      int sa;
      int sb;
      int p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[15:0];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_a(input logic [7:0] a);
      bus.sw = a;
      bus.go = 1'b1;
      tick();
      cur_a = a;
      check("a_state", {13'd0, bus.state}, 16'd1);
      check("a_echo", bus.display, {a, 8'h00});
      bus.go = 1'b0;
      tick();
   endtask

   task automatic do_b(input logic [7:0] b, input logic [15:0] exp);
      bus.sw = b;
      bus.go = 1'b1;
      exp_q.push_back(exp);
      cap_q.push_back(cyc + 1);
      tick();
      check("b_state", {13'd0, bus.state}, 16'd2);
      check("b_echo", bus.display, {cur_a, b});
      bus.go = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: state %0d expected 4 within 20 cycles", bus.state);
         exp_q.delete();
         cap_q.delete();
      end
      tick();
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
      do_a(a);
      do_b(b, exp);
      wait_done();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst && bus.state == 3'd4 && prev_state != 3'd4) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: display %h with no product pending", bus.display);
         end else begin
            logic [15:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            check("product", bus.display, e);
            check("latency", 16'(cyc - c), 16'd5);
         end
      end
      prev_state = bus.state;
   end

   // ---------------- stimulus ----------------
   logic [7:0] ca[5] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h80};
   logic [7:0] cb[5] = '{8'h80, 8'h01, 8'h80, 8'hB3, 8'h7F};
   logic [15:0] cp[5] = '{16'h4000, 16'hFFFF, 16'hC080, 16'h0000, 16'hC080};
   logic [7:0] corner_vals[5] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F};

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      bus.sw = 8'h00;
      bus.go = 1'b0;
      rst    = 1'b0;
      repeat (3) tick();
      check("reset_state", {13'd0, bus.state}, 16'd0);
      check("reset_display", bus.display, 16'h0000);
      rst = 1'b1;
      tick();

      // Basic example from the datasheet.
      run_op(8'd68, 8'd35, 16'h094C);

      // Asynchronous reset mid-stream, then idle after release.
      do_a(8'd12);
      #2 rst = 1'b0;
      #1;
      check("async_rst_state", {13'd0, bus.state}, 16'd0);
      check("async_rst_display", bus.display, 16'h0000);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      check("post_rst_state", {13'd0, bus.state}, 16'd0);
      check("post_rst_display", bus.display, 16'h0000);

      // Signed corners.
      for (int i = 0; i < 5; i++) run_op(ca[i], cb[i], cp[i]);

      // go held high after the A capture: only one capture.
      bus.sw = 8'd68;
      bus.go = 1'b1;
      tick();
      cur_a = 8'd68;
      check("hold_a_state", {13'd0, bus.state}, 16'd1);
      for (int i = 0; i < 6; i++) begin
         bus.sw = 8'(i + 90);
         tick();
         check("hold_state", {13'd0, bus.state}, 16'd1);
         check("hold_display", bus.display, 16'h4400);
      end
      bus.go = 1'b0;
      tick();
      do_b(8'd35, 16'h094C);
      wait_done();

      // go toggled while busy: no effect on result or latency.
      do_a(8'hC3);
      do_b(8'h5A, model(8'hC3, 8'h5A));
      bus.sw = 8'h11;
      tick();
      bus.go = 1'b1; tick();
      bus.go = 1'b0; tick();
      bus.go = 1'b1; tick();
      bus.go = 1'b0;
      wait_done();
      check("no_capture_in_done", {13'd0, bus.state}, 16'd4);

      // Abort during CALC.
      do_a(8'd68);
      do_b(8'd35, 16'h094C);
      tick();
      tick();
      check("abort_in_calc", {13'd0, bus.state}, 16'd3);
      #2 rst = 1'b0;
      #1;
      exp_q.delete();
      cap_q.delete();
      check("abort_state", {13'd0, bus.state}, 16'd0);
      check("abort_display", bus.display, 16'h0000);
      tick();
      rst = 1'b1;
      tick();
      run_op(8'd68, 8'd35, 16'h094C);

      // Random pairs, biased toward the extreme values.
      for (int n = 0; n < 300; n++) begin
         ra = ($urandom_range(0, 3) == 0) ? corner_vals[$urandom_range(0, 4)] : 8'($urandom_range(0, 255));
         rb = ($urandom_range(0, 3) == 0) ? corner_vals[$urandom_range(0, 4)] : 8'($urandom_range(0, 255));
         run_op(ra, rb, model(ra, rb));
      end

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
